// File: rtl/vanilla_exe_bubble_classifier_pkg.sv
// EXE-stage bubble classification types shared by the classifier and the bubble profiler.
// The counted bubble types sit at codes 0..N-1 so they can index the counter bank directly.
package vanilla_exe_bubble_classifier_pkg;

  typedef enum logic [31:0] {
    e_exe_bubble_branch_miss = 32'd0,
    e_exe_bubble_jalr_miss   = 32'd1,
    e_exe_bubble_icache_miss = 32'd2,
    e_exe_no_bubble          = 32'd3
  } exe_bubble_type_e;

  // Number of exe_bubble_type_e members other than e_exe_no_bubble
  localparam int unsigned num_exe_bubble_types_gp = 3;

  typedef enum logic [1:0] {
    e_prof_idle,
    e_prof_count,
    e_prof_dump
  } bubble_prof_state_e;

endpackage

// File: rtl/vanilla_bubble_sat_counter.sv
// Saturating event counter for one bubble type.
// A clear and an increment in the same cycle leave the counter at 1.
module vanilla_bubble_sat_counter #(
  parameter int unsigned ctr_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   inc_i,
  output logic [ctr_width_p-1:0] count_o
);

  logic [ctr_width_p-1:0] count_r, base, count_n;

  always_comb begin
    base    = clear_i ? '0 : count_r;
    count_n = base;
    if (inc_i && (base != '1))
      count_n = base + ctr_width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_r <= '0;
    else         count_r <= count_n;
  end

  assign count_o = count_r;

endmodule

// File: rtl/vanilla_exe_bubble_profiler.sv
// Per-tile histogram of EXE bubble cycles by type, dumped over valid/ready with clear-on-read.
// Define VANILLA_BUBBLE_PROFILER_PC_TRACK_EN to also keep the last blamed PC per type.
module vanilla_exe_bubble_profiler
  import vanilla_exe_bubble_classifier_pkg::*;
#(
  parameter int unsigned num_types_p = num_exe_bubble_types_gp,
  parameter int unsigned ctr_width_p = 32,
  parameter int unsigned pc_width_p  = 32,
  localparam int unsigned idx_width_lp = (num_types_p > 1) ? $clog2(num_types_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    stall_all_i,
  input  logic [31:0]             exe_bubble_type_i,
  input  logic [pc_width_p-1:0]   exe_bubble_pc_i,
  input  logic                    dump_i,
  output logic                    dump_v_o,
  input  logic                    dump_ready_i,
  output logic [idx_width_lp-1:0] dump_type_o,
  output logic [ctr_width_p-1:0]  dump_count_o,
  output logic [pc_width_p-1:0]   dump_pc_o,
  output logic                    busy_o
);

  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_types_p - 1);

  bubble_prof_state_e      state_r, state_n;
  logic [idx_width_lp-1:0] index_r, index_n;
  logic [idx_width_lp-1:0] sample_idx;
  logic                    sample_v, dump_hs;
  logic [ctr_width_p-1:0]  count_lo [num_types_p];

  assign sample_idx = exe_bubble_type_i[idx_width_lp-1:0];
  assign sample_v   = en_i && (state_r != e_prof_idle) && !stall_all_i
                   && (exe_bubble_type_i < 32'(num_types_p))
                   && (exe_bubble_type_i != e_exe_no_bubble);
  assign dump_hs    = (state_r == e_prof_dump) && dump_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_prof_idle;
      index_r <= '0;
    end else begin
      state_r <= state_n;
      index_r <= index_n;
    end
  end

  always_comb begin
    state_n = state_r;
    index_n = index_r;
    unique case (state_r)
      e_prof_idle, e_prof_count: begin
        if (dump_i) begin
          state_n = e_prof_dump;
          index_n = '0;
        end else if (en_i) begin
          state_n = e_prof_count;
        end else begin
          state_n = e_prof_idle;
        end
      end
      e_prof_dump: begin
        if (dump_hs) begin
          if (index_r == last_idx_lp) begin
            state_n = en_i ? e_prof_count : e_prof_idle;
            index_n = '0;
          end else begin
            index_n = index_r + idx_width_lp'(1);
          end
        end
      end
      default: begin
        state_n = e_prof_idle;
        index_n = '0;
      end
    endcase
  end

  for (genvar i = 0; i < num_types_p; i++) begin : ctr
    vanilla_bubble_sat_counter #(.ctr_width_p(ctr_width_p)) cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (dump_hs && (index_r == idx_width_lp'(i))),
      .inc_i   (sample_v && (sample_idx == idx_width_lp'(i))),
      .count_o (count_lo[i])
    );
  end

  assign dump_v_o     = (state_r == e_prof_dump);
  assign busy_o       = (state_r == e_prof_dump);
  assign dump_type_o  = index_r;
  assign dump_count_o = count_lo[index_r];

`ifdef VANILLA_BUBBLE_PROFILER_PC_TRACK_EN
  logic [pc_width_p-1:0] pc_r [num_types_p];

  // A new sample overrides the read-clear on the same type, matching the counter rule
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_r <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < num_types_p; i++) begin
        if (sample_v && (sample_idx == idx_width_lp'(i)))
          pc_r[i] <= exe_bubble_pc_i;
        else if (dump_hs && (index_r == idx_width_lp'(i)))
          pc_r[i] <= '0;
      end
    end
  end

  assign dump_pc_o = pc_r[index_r];
`else
  logic unused_pc;
  assign unused_pc = ^exe_bubble_pc_i;
  assign dump_pc_o = '0;
`endif

endmodule
